// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Bytes written on wdata/wr are queued in a circular buffer. A three-state
// drain FSM hands them one at a time to the transmitter through a registered
// tx_data/tx_write strobe. After each strobe it waits for tx_ready to fall
// and then rise again before it sends the next byte.
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            wdata,
   input  logic                  wr,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   input  logic                  clear_overflow,
   output logic [7:0]            tx_data,
   output logic                  tx_write,
   input  logic                  tx_ready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_LOW,
      WAIT_HIGH
   } state_t;

   state_t                  state;
   logic [7:0]              mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr;
   logic [DEPTH_LOG2-1:0]   rd_ptr;
   logic                    accept;
   logic                    pop;
   logic [DEPTH_LOG2:0]     count_next;

   // Accept and pop decisions. full is the registered flag, so a write that
   // arrives while full is refused even if a pop frees a slot in that cycle.
   always_comb begin
      accept = wr && !full;
      pop    = (state == IDLE) && (count != '0) && tx_ready;
   end

   // Next occupancy. A simultaneous accept and pop leaves the count unchanged.
   always_comb begin
      count_next = count;
      case ({accept, pop})
         2'b10:   count_next = count + (DEPTH_LOG2+1)'(1);
         2'b01:   count_next = count - (DEPTH_LOG2+1)'(1);
         default: count_next = count;
      endcase
   end

   // Storage array. It needs no reset because count decides which entries are valid.
   always_ff @(posedge clk) begin
      if (reset && accept) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers, occupancy, full flag and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         count <= count_next;
         full  <= (count_next == DEPTH_CNT);
         if (wr && full) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // Drain FSM. It issues one byte, then waits for the transmitter to go busy
   // and idle again before it sends the next one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         tx_write <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         tx_write <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data  <= mem[rd_ptr];
                  tx_write <= 1'b1;
                  state    <= WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (!tx_ready) begin
                  state <= WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               if (tx_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (16).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: wdata  input  8  byte to enqueue.
REQ-005 Port: wr  input  1  enqueue strobe, one byte per cycle high.
REQ-006 Port: full  output  1  registered; high when count == DEPTH.
REQ-007 Port: count  output  DEPTH_LOG2+1  registered occupancy, 0..DEPTH.
REQ-008 Port: overflow  output  1  sticky; set by a write while full.
REQ-009 Port: clear_overflow  input  1  clears overflow.
REQ-010 Port: tx_data  output  8  registered byte presented to the UART transmitter.
REQ-011 Port: tx_write  output  1  registered one-cycle strobe to the transmitter's write input.
REQ-012 Port: tx_ready  input  1  transmitter idle flag; drops the cycle after an accepted write, rises at end of stop bit.

Function
REQ-013 Storage: circular buffer, DEPTH_LOG2-bit read/write pointers, natural wrap from DEPTH-1 to 0.
REQ-014 Write accepted iff wr==1 and full==0; byte stored at write pointer, pointer increments.
REQ-015 wr==1 while full==1: byte dropped, pointers/count unchanged, overflow set next cycle.
REQ-016 Overflow stays set until clear_overflow==1; clear_overflow and overflow-setting write in same cycle: overflow ends set.
REQ-017 Pop: one byte removed at read pointer in the cycle the drain FSM issues tx_write.
REQ-018 Simultaneous accepted write and pop: count unchanged, both pointers advance.
REQ-019 full and count update on the edge following the accepting/popping cycle.
REQ-020 Drain FSM states: IDLE, WAIT_LOW, WAIT_HIGH.
REQ-021 IDLE: if count != 0 and tx_ready==1, register tx_data <= head byte, tx_write <= 1, pop, go WAIT_LOW; else stay.
REQ-022 tx_write SHALL be high exactly one cycle per byte; tx_data held stable until next issue.
REQ-023 WAIT_LOW: stay until tx_ready==0, then go WAIT_HIGH.
REQ-024 WAIT_HIGH: stay until tx_ready==1, then go IDLE.
REQ-025 Latency: write into empty FIFO in cycle N with tx_ready high and FSM in IDLE -> tx_write high in cycle N+2.
REQ-026 Back-to-back bytes: next tx_write no earlier than one cycle after tx_ready returns high.
REQ-027 Byte order out equals byte order accepted; no byte duplicated or skipped.
REQ-028 Write to full FIFO in the same cycle as a pop: still rejected (full is registered), overflow set.

Reset
REQ-029 While reset==0 at a clock edge: pointers 0, count 0, full 0, overflow 0, tx_write 0, tx_data 8'h00, FSM IDLE.
REQ-030 Reset mid-transmission discards all queued bytes and aborts the wait; the transmitter finishes its current frame independently.
REQ-031 wr and clear_overflow ignored in any cycle reset==0.

Verification
REQ-032 Single byte: write 8'hA5 to empty FIFO, tx_ready=1 -> tx_write pulse 2 cycles later with tx_data=8'hA5, count 1 then 0.
REQ-033 Ordering: write 8'h01..8'h05 back-to-back, transmitter model busy 160 cycles per byte -> five tx_write pulses carrying 8'h01..8'h05 in order, each after tx_ready rises.
REQ-034 Full/overflow: tx_ready held 0, write 17 bytes -> count=16, full=1, overflow=1, 17th byte never transmitted; pulse clear_overflow -> overflow=0.
REQ-035 Wrap-around: 40 writes interleaved with drains (pointers wrap twice) -> output sequence matches input exactly.
REQ-036 Simultaneous: count=3, write and pop in same cycle -> count stays 3.
REQ-037 Reset mid-operation: 6 bytes queued, FSM in WAIT_HIGH, reset low one cycle -> count=0, tx_write=0, FSM IDLE, no further tx_write until new write.
